// File: rtl/uart_baud_pkg.sv
// Purpose: shared constants, types and elaboration-time math for the UART baud tick generator.
// Latency: n/a (package only; everything here is evaluated at elaboration).
// Backpressure: n/a.
package uart_baud_pkg;

    // Number of defined rate codes; codes at or above this fold to the default.
    localparam int unsigned NUM_RATES = 12;

    // Rate code selected out of reset and substituted for undefined codes (9600 baud).
    localparam logic [3:0] DEFAULT_CODE = 4'd4;

    // Sub-tick counter width: covers OVERSAMPLE up to 64 (values 0..63).
    localparam int unsigned SUB_W = 6;

    // Baud rate per code, index = code.
    localparam int unsigned BAUD_RATES [NUM_RATES] = '{
        300, 1200, 2400, 4800, 9600, 19200,
        38400, 57600, 115200, 230400, 460800, 921600
    };

    // Counter sequencing: after reset the first enabled edge only arms the
    // generator, so counting begins from 0 on that edge rather than already
    // having advanced.
    typedef enum logic {
        GEN_ARMED = 1'b0,
        GEN_RUN   = 1'b1
    } gen_state_t;

    // Oversample divisor: round-half-up(clk_hz / (rate * oversample)), min 1.
    // Written as (2*clk + den) / (2*den) so the rounding stays in integers.
    function automatic logic [63:0] calc_div(input logic [63:0] clk_hz,
                                             input logic [63:0] oversample,
                                             input logic [63:0] rate);
        logic [63:0] den;
        logic [63:0] q;
        den = rate * oversample;
        if (den == 64'd0) begin
            q = 64'd1;
        end else begin
            q = (64'd2 * clk_hz + den) / (64'd2 * den);
        end
        if (q == 64'd0) begin
            q = 64'd1;
        end
        return q;
    endfunction

    // Map undefined codes onto the default rate.
    function automatic logic [3:0] fold_code(input logic [3:0] code);
        return (code < 4'(NUM_RATES)) ? code : DEFAULT_CODE;
    endfunction

endpackage

// File: rtl/baud_div_rom.sv
// Purpose: combinational rate-code to oversample-divisor lookup, with undefined codes folded to 9600.
// Latency: 0 cycles (pure combinational table built at elaboration).
// Backpressure: none; output follows input every cycle.
//
// Ports:
//   code - requested rate code (any 4-bit value)
//   sel  - effective rate code after folding undefined codes
//   div  - oversample divisor for the effective rate
import uart_baud_pkg::*;

module baud_div_rom #(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned CNT_W      = 19
) (
    input  logic [3:0]       code,
    output logic [3:0]       sel,
    output logic [CNT_W-1:0] div
);

    // Full 16-entry table so any 4-bit code indexes a real entry; the upper
    // entries already carry the default divisor.
    logic [CNT_W-1:0] div_tab [16];

    for (genvar i = 0; i < 16; i++) begin : g_tab
        localparam logic [3:0]  ENTRY_CODE = fold_code(4'(i));
        localparam logic [63:0] DIV_FULL   = calc_div(64'(CLK_HZ), 64'(OVERSAMPLE),
                                                      64'(BAUD_RATES[ENTRY_CODE]));

        // A divisor that does not fit the counter would silently alias to a
        // wrong rate, so refuse to elaborate instead.
        if (DIV_FULL >= (64'd1 << CNT_W)) begin : g_div_too_wide
            $error("baud_div_rom: divisor for code %0d does not fit in CNT_W bits", i);
        end

        assign div_tab[i] = DIV_FULL[CNT_W-1:0];
    end

    always_comb begin
        sel = fold_code(code);
        div = div_tab[code];
    end

endmodule

// File: rtl/baud_tick_gen.sv
// Purpose: UART baud tick generator; rx_tick at OVERSAMPLE x baud, tx_tick at 1 x baud, phase-locked.
// Latency: ticks registered; first rx_tick os_div edges after a load, first tx_tick OVERSAMPLE*os_div edges after.
// Backpressure: en=0 freezes both counters and forces ticks low, stretching periods by the disabled cycles.
//
// Ports:
//   clk          - system clock, rising edge
//   rst          - asynchronous active-low reset
//   en           - count enable
//   baud_load    - strobe capturing baud_control; restarts both counters
//   baud_control - requested rate code
//   rx_tick      - one-cycle pulse every os_div cycles
//   tx_tick      - one-cycle pulse every OVERSAMPLE rx ticks, coincident with an rx_tick
//   baud_sel     - active (folded) rate code
//   os_div       - active oversample divisor
import uart_baud_pkg::*;

module baud_tick_gen #(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned CNT_W      = 19
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             baud_load,
    input  logic [3:0]       baud_control,
    output logic             rx_tick,
    output logic             tx_tick,
    output logic [3:0]       baud_sel,
    output logic [CNT_W-1:0] os_div
);

    if (OVERSAMPLE < 1 || OVERSAMPLE > 64) begin : g_bad_oversample
        $error("baud_tick_gen: OVERSAMPLE must be in 1..64");
    end

    localparam logic [63:0]       RST_DIV_FULL = calc_div(64'(CLK_HZ), 64'(OVERSAMPLE),
                                                          64'(BAUD_RATES[DEFAULT_CODE]));
    localparam logic [CNT_W-1:0]  RST_DIV      = RST_DIV_FULL[CNT_W-1:0];
    localparam logic [SUB_W-1:0]  SUB_LAST     = SUB_W'(OVERSAMPLE - 1);

    logic [3:0]       rom_sel;
    logic [CNT_W-1:0] rom_div;

    baud_div_rom #(
        .CLK_HZ     (CLK_HZ),
        .OVERSAMPLE (OVERSAMPLE),
        .CNT_W      (CNT_W)
    ) u_div_rom (
        .code (baud_control),
        .sel  (rom_sel),
        .div  (rom_div)
    );

    gen_state_t       state;
    logic [CNT_W-1:0] os_cnt;
    logic [SUB_W-1:0] sub_cnt;
    logic             os_wrap;
    logic             sub_wrap;

    // os_div >= 1 always, so os_div-1 never underflows; with os_div=1 the
    // counter sits at 0 and wraps every enabled cycle.
    assign os_wrap  = (os_cnt == (os_div - CNT_W'(1)));
    assign sub_wrap = (sub_cnt == SUB_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= GEN_ARMED;
            os_cnt   <= '0;
            sub_cnt  <= '0;
            rx_tick  <= 1'b0;
            tx_tick  <= 1'b0;
            baud_sel <= DEFAULT_CODE;
            os_div   <= RST_DIV;
        end else if (baud_load) begin
            // The load edge itself is cycle 0 of the new period, whether or
            // not en is high, so the generator is left running.
            state    <= GEN_RUN;
            os_cnt   <= '0;
            sub_cnt  <= '0;
            rx_tick  <= 1'b0;
            tx_tick  <= 1'b0;
            baud_sel <= rom_sel;
            os_div   <= rom_div;
        end else if (!en) begin
            rx_tick  <= 1'b0;
            tx_tick  <= 1'b0;
        end else if (state == GEN_ARMED) begin
            // First enabled edge after reset: counters stay at 0 here.
            state    <= GEN_RUN;
            rx_tick  <= 1'b0;
            tx_tick  <= 1'b0;
        end else if (os_wrap) begin
            os_cnt   <= '0;
            rx_tick  <= 1'b1;
            if (sub_wrap) begin
                sub_cnt <= '0;
                tx_tick <= 1'b1;
            end else begin
                sub_cnt <= sub_cnt + SUB_W'(1);
                tx_tick <= 1'b0;
            end
        end else begin
            os_cnt   <= os_cnt + CNT_W'(1);
            rx_tick  <= 1'b0;
            tx_tick  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_baud_tick_gen.sv
// Purpose: directed self-checking bench for baud_tick_gen at 100 MHz, 16x oversample.
// Latency: n/a.
// Backpressure: n/a.
module tb_baud_tick_gen;

    logic        clk;
    logic        rst;
    logic        en;
    logic        baud_load;
    logic [3:0]  baud_control;
    logic        rx_tick;
    logic        tx_tick;
    logic [3:0]  baud_sel;
    logic [18:0] os_div;

    int checks = 0;
    int errors = 0;

    baud_tick_gen #(
        .CLK_HZ     (100_000_000),
        .OVERSAMPLE (16),
        .CNT_W      (19)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .baud_load    (baud_load),
        .baud_control (baud_control),
        .rx_tick      (rx_tick),
        .tx_tick      (tx_tick),
        .baud_sel     (baud_sel),
        .os_div       (os_div)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle; outputs then reflect that edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Edges until rx_tick is seen; returns limit+1 if it never shows.
    task automatic run_until_rx(input int limit, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!rx_tick && n <= limit);
    endtask

    // Edges until tx_tick is seen, also recording rx activity on the way.
    task automatic run_until_tx(input int limit, output int n, output int rx_seen, output int first_rx);
        n = 0;
        rx_seen = 0;
        first_rx = 0;
        do begin
            tick();
            n++;
            if (rx_tick) begin
                rx_seen++;
                if (first_rx == 0) first_rx = n;
            end
        end while (!tx_tick && n <= limit);
    endtask

    // Run a fixed number of edges, counting cycles with any tick high.
    task automatic run_quiet(input int cycles, output int ticks);
        ticks = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (rx_tick || tx_tick) ticks++;
        end
    endtask

    task automatic do_load(input logic [3:0] code);
        baud_control = code;
        baud_load = 1'b1;
        tick();
        baud_load = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en = 1'b0;
        baud_load = 1'b0;
        baud_control = 4'd0;
        #2 rst = 1'b0;
        #1;
        checks++; if (rx_tick !== 1'b0) begin errors++; $display("FAIL reset_rx got %0b want 0", rx_tick); end
        checks++; if (tx_tick !== 1'b0) begin errors++; $display("FAIL reset_tx got %0b want 0", tx_tick); end
        checks++; if (baud_sel !== 4'd4) begin errors++; $display("FAIL reset_sel got %0d want 4", baud_sel); end
        checks++; if (os_div !== 19'd651) begin errors++; $display("FAIL reset_div got %0d want 651", os_div); end
    endtask

    task automatic test_default_rate();
        int n, rx_seen, first_rx;
        rst = 1'b1;
        en = 1'b1;
        tick();  // first enabled edge
        run_until_tx(11000, n, rx_seen, first_rx);
        checks++; if (first_rx !== 651) begin errors++; $display("FAIL default_first_rx got %0d want 651", first_rx); end
        checks++; if (n !== 10416) begin errors++; $display("FAIL default_first_tx got %0d want 10416", n); end
        checks++; if (rx_seen !== 16) begin errors++; $display("FAIL default_rx_per_tx got %0d want 16", rx_seen); end
    endtask

    task automatic test_load_115200();
        int n, rx_seen, first_rx;
        do_load(4'b1000);
        checks++; if (baud_sel !== 4'd8) begin errors++; $display("FAIL load8_sel got %0d want 8", baud_sel); end
        checks++; if (os_div !== 19'd54) begin errors++; $display("FAIL load8_div got %0d want 54", os_div); end
        checks++; if ({rx_tick, tx_tick} !== 2'b00) begin errors++; $display("FAIL load8_quiet got %0b want 00", {rx_tick, tx_tick}); end
        run_until_tx(1000, n, rx_seen, first_rx);
        checks++; if (first_rx !== 54) begin errors++; $display("FAIL load8_first_rx got %0d want 54", first_rx); end
        checks++; if (n !== 864) begin errors++; $display("FAIL load8_first_tx got %0d want 864", n); end
        checks++; if (rx_seen !== 16) begin errors++; $display("FAIL load8_rx_per_tx got %0d want 16", rx_seen); end
        run_until_tx(1000, n, rx_seen, first_rx);
        checks++; if (n !== 864) begin errors++; $display("FAIL load8_tx_period got %0d want 864", n); end
    endtask

    task automatic test_fold_and_fastest();
        int n, rx_seen, first_rx;
        do_load(4'b1101);
        checks++; if (baud_sel !== 4'd4) begin errors++; $display("FAIL fold_sel got %0d want 4", baud_sel); end
        checks++; if (os_div !== 19'd651) begin errors++; $display("FAIL fold_div got %0d want 651", os_div); end
        do_load(4'b1011);
        checks++; if (baud_sel !== 4'd11) begin errors++; $display("FAIL fast_sel got %0d want 11", baud_sel); end
        checks++; if (os_div !== 19'd7) begin errors++; $display("FAIL fast_div got %0d want 7", os_div); end
        run_until_tx(200, n, rx_seen, first_rx);
        checks++; if (first_rx !== 7) begin errors++; $display("FAIL fast_first_rx got %0d want 7", first_rx); end
        checks++; if (n !== 112) begin errors++; $display("FAIL fast_first_tx got %0d want 112", n); end
        run_until_tx(200, n, rx_seen, first_rx);
        checks++; if (n !== 112) begin errors++; $display("FAIL fast_tx_period got %0d want 112", n); end
        run_until_rx(20, n);
        checks++; if (n !== 7) begin errors++; $display("FAIL fast_rx_period got %0d want 7", n); end
    endtask

    task automatic test_reload();
        int n, ticks;
        do_load(4'd4);
        run_quiet(300, ticks);
        checks++; if (ticks !== 0) begin errors++; $display("FAIL reload_quiet got %0d want 0", ticks); end
        do_load(4'd8);
        run_until_rx(100, n);
        checks++; if (n !== 54) begin errors++; $display("FAIL reload_first_rx got %0d want 54", n); end
    endtask

    task automatic test_enable_hold();
        int n, ticks;
        do_load(4'd4);
        run_until_rx(1000, n);
        checks++; if (n !== 651) begin errors++; $display("FAIL hold_period got %0d want 651", n); end
        run_quiet(200, ticks);
        en = 1'b0;
        run_quiet(100, ticks);
        checks++; if (ticks !== 0) begin errors++; $display("FAIL hold_disabled_ticks got %0d want 0", ticks); end
        en = 1'b1;
        run_until_rx(1000, n);
        checks++; if (n + 300 !== 751) begin errors++; $display("FAIL hold_stretched got %0d want 751", n + 300); end
        // Load while disabled: takes effect, counters wait for en.
        en = 1'b0;
        do_load(4'd5);
        checks++; if (os_div !== 19'd326) begin errors++; $display("FAIL load_dis_div got %0d want 326", os_div); end
        run_quiet(20, ticks);
        checks++; if (ticks !== 0) begin errors++; $display("FAIL load_dis_ticks got %0d want 0", ticks); end
        en = 1'b1;
        run_until_rx(1000, n);
        checks++; if (n !== 326) begin errors++; $display("FAIL load_dis_first_rx got %0d want 326", n); end
    endtask

    task automatic test_load_held();
        int n, ticks;
        baud_control = 4'd11;
        baud_load = 1'b1;
        run_quiet(20, ticks);
        baud_load = 1'b0;
        checks++; if (ticks !== 0) begin errors++; $display("FAIL held_load_ticks got %0d want 0", ticks); end
        run_until_rx(50, n);
        checks++; if (n !== 7) begin errors++; $display("FAIL held_load_first_rx got %0d want 7", n); end
    endtask

    task automatic test_realign();
        int n, ticks;
        run_until_rx(50, n);
        run_quiet(3, ticks);
        do_load(4'd11);
        run_until_rx(50, n);
        checks++; if (n !== 7) begin errors++; $display("FAIL realign_first_rx got %0d want 7", n); end
    endtask

    task automatic test_async_reset();
        int n;
        do_load(4'd8);
        run_until_rx(100, n);
        checks++; if (rx_tick !== 1'b1) begin errors++; $display("FAIL areset_pre_rx got %0b want 1", rx_tick); end
        #2 rst = 1'b0;
        #1;
        checks++; if (rx_tick !== 1'b0) begin errors++; $display("FAIL areset_rx got %0b want 0", rx_tick); end
        checks++; if (baud_sel !== 4'd4) begin errors++; $display("FAIL areset_sel got %0d want 4", baud_sel); end
        checks++; if (os_div !== 19'd651) begin errors++; $display("FAIL areset_div got %0d want 651", os_div); end
        #2 rst = 1'b1;
        tick();  // first enabled edge after release
        run_until_rx(1000, n);
        checks++; if (n !== 651) begin errors++; $display("FAIL areset_first_rx got %0d want 651", n); end
    endtask

    initial begin
        test_reset();
        test_default_rate();
        test_load_115200();
        test_fold_and_fastest();
        test_reload();
        test_enable_hold();
        test_load_held();
        test_realign();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/baud_tick_gen.md
BAUD_TICK_GEN -- requirements
Module: baud_tick_gen

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000, system clock frequency in Hz.
REQ-002 Parameter OVERSAMPLE, default 16, receiver ticks per bit; legal range 1..64.
REQ-003 Parameter CNT_W, default 19, width of the divisor and counter.
REQ-004 clk  input  1  system clock; all state changes on the rising edge.
REQ-005 rst  input  1  reset; asynchronous and active-low.
REQ-006 en  input  1  count enable.
REQ-007 baud_load  input  1  single-cycle strobe that captures baud_control.
REQ-008 baud_control  input  4  rate select code.
REQ-009 rx_tick  output  1  one-cycle pulse at OVERSAMPLE x baud rate, registered.
REQ-010 tx_tick  output  1  one-cycle pulse at 1 x baud rate, registered.
REQ-011 baud_sel  output  4  active rate code.
REQ-012 os_div  output  CNT_W  active oversample divisor.

Function
REQ-013 Codes 0..11 SHALL map to 300, 1200, 2400, 4800, 9600, 19200, 38400, 57600, 115200, 230400, 460800 and 921600 baud respectively.
REQ-014 Codes 12..15 SHALL be treated as code 4 (9600); baud_sel SHALL then read 4.
REQ-015 os_div SHALL equal round-half-up(CLK_HZ / (rate * OVERSAMPLE)), clamped to a minimum of 1, computed at elaboration only.
REQ-016 There SHALL be no runtime divider.
REQ-017 Elaboration SHALL fail if any os_div does not fit in CNT_W bits.
REQ-018 Counters:
  - os_cnt counts 0..os_div-1 and wraps to 0.
  - sub_cnt counts 0..OVERSAMPLE-1 and advances only when os_cnt wraps.
REQ-019 rx_tick SHALL be high for exactly the one cycle after os_cnt wraps.
REQ-020 tx_tick SHALL be high in the same cycle as the rx_tick that accompanies sub_cnt wrapping; tx is phase-locked to rx.
REQ-021 The rx_tick period SHALL be exactly os_div cycles, and the tx_tick period exactly OVERSAMPLE*os_div cycles, while en=1 and no load occurs.
REQ-022 When en=0:
  - Both counters hold their value.
  - Both ticks are 0.
  - Periods are stretched by exactly the number of disabled cycles.
REQ-023 On baud_load=1 at edge t:
  - baud_sel and os_div update at t.
  - Both counters clear to 0.
  - No tick is produced in cycle t+1.
REQ-024 After a load, the first rx_tick SHALL be at t+os_div and the first tx_tick at t+OVERSAMPLE*os_div, given en=1 throughout.
REQ-025 If baud_load=1 and en=0 together, the load SHALL take effect and the counters SHALL stay at 0 until en rises.
REQ-026 baud_load held high for N cycles SHALL keep the counters at 0 for those N cycles, with no ticks.
REQ-027 A load with the same code SHALL still restart the counters (phase re-alignment).
REQ-028 No tick SHALL ever be wider than one cycle, including when os_div=1: rx_tick is then high every cycle and tx_tick every OVERSAMPLE cycles.

Reset
REQ-029 While rst=0:
  - os_cnt=0, sub_cnt=0.
  - rx_tick=0, tx_tick=0.
  - baud_sel=4, os_div=9600 divisor.
REQ-030 Reset asserted mid-period SHALL take effect immediately without waiting for a clock edge.
REQ-031 After release, counting SHALL start from 0 on the first edge with en=1.

Structure
REQ-032 Package uart_baud_pkg SHALL hold:
  - the rate table constant (12 entries);
  - the default code (4);
  - the elaboration function that computes the divisor from CLK_HZ, OVERSAMPLE and rate.
REQ-033 Sub-module baud_div_rom SHALL be instantiated once: a parametrised combinational code-to-divisor lookup built from the package function, including the invalid-code fold.
REQ-034 All counters and tick flops SHALL live in baud_tick_gen.

Verification (CLK_HZ=100_000_000, OVERSAMPLE=16)
REQ-035 Reset release, en=1, no load -> baud_sel=4, os_div=651, rx_tick every 651 cycles, tx_tick every 10416 cycles.
REQ-036 Load code 4'b1000 -> os_div=54, rx_tick every 54 cycles, tx_tick every 864 cycles, first rx_tick at load+54.
REQ-037 Load code 4'b1101 -> baud_sel=4, os_div=651; load code 4'b1011 -> os_div=7 (6.78 rounded), tx_tick every 112 cycles.
REQ-038 Load 9600 with en=1 and 300 cycles elapsed, then load 115200 -> no rx_tick for 54 cycles, first rx_tick exactly 54 cycles after the second load.
REQ-039 9600 running, en=0 for 100 cycles after cycle 200 of the period -> next rx_tick at cycle 751 of the period, ticks 0 while disabled.
REQ-040 rst pulsed low asynchronously for 3 ns mid-period -> outputs reach reset values before the next edge, and the next rx_tick is 651 cycles after the first enabled edge.
